// File: rtl/approx_cmp_seq_if.sv
// Operand/result handshake bundle for the approximate comparator that drives the 2:1 max mux.
interface approx_cmp_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             sel;
    logic             eq;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sel, eq, a_q, b_q
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sel, eq, a_q, b_q
    );
endinterface

// File: rtl/approx_cmp_seq.sv
// Bit-serial MSB-first magnitude comparator over the top EXACT_BITS bits, exiting on the
// first differing bit; sel picks a_q (1) or b_q (0) so the downstream mux yields the max.
module approx_cmp_seq #(
    parameter int WIDTH      = 8,
    parameter int EXACT_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    approx_cmp_seq_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - EXACT_BITS);

    if (EXACT_BITS < 1 || EXACT_BITS > WIDTH) begin : g_bad_exact_bits
        $error("approx_cmp_seq: EXACT_BITS must lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             in_ready;
    logic             out_valid;
    logic             sel;
    logic             eq;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Operands, decision and handshake flags are all registered; the mux sees stable values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sel       <= 1'b0;
            eq        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        idx      <= START_IDX;
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (a_q[idx] != b_q[idx]) begin
                        sel       <= a_q[idx];
                        eq        <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == LAST_IDX) begin
                        // Window exhausted: treat as a tie, which routes B through the mux.
                        sel       <= 1'b0;
                        eq        <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sel       = sel;
    assign bus.eq        = eq;
    assign bus.a_q       = a_q;
    assign bus.b_q       = b_q;
endmodule
